// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port ROM among N_REQ pixel fetchers.
// Define ROM_ARB_FIXED_PRI_EN for fixed priority (index 0 highest) instead of round-robin.
module rom_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                      vga_clk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_REQ-1:0]          rvalid
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW:0]   NQ   = (PW+1)'(N_REQ);
    localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

    logic [PW-1:0]    base;
    logic [PW-1:0]    win;
    logic             any;
    logic [N_REQ-1:0] oh;
    logic [PW:0]      scan;
    logic [PW-1:0]    idx;
    logic             tag1_v;
    logic [N_REQ-1:0] tag1;
    logic [N_REQ-1:0] rvalid_q;

`ifdef ROM_ARB_FIXED_PRI_EN
    assign base = '0;
`else
    logic [PW-1:0] ptr;
    assign base = ptr;
`endif

    // Scan from base upward with wrap; first asserted request wins.
    always_comb begin
        win  = '0;
        any  = 1'b0;
        oh   = '0;
        scan = '0;
        idx  = '0;
        for (int j = 0; j < N_REQ; j++) begin
            scan = {1'b0, base} + (PW+1)'(j);
            if (scan >= NQ) scan = scan - NQ;
            idx = scan[PW-1:0];
            if (!any && req[idx]) begin
                any     = 1'b1;
                win     = idx;
                oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        gnt         = '0;
        rom_address = '0;
        if (!Reset && any) begin
            gnt = oh;
            for (int i = 0; i < N_REQ; i++)
                if (oh[i]) rom_address = addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
`ifndef ROM_ARB_FIXED_PRI_EN
            ptr      <= '0;
`endif
            tag1_v   <= 1'b0;
            tag1     <= '0;
            rvalid_q <= '0;
            rdata    <= '0;
        end else begin
`ifndef ROM_ARB_FIXED_PRI_EN
            if (any) ptr <= (win == LAST) ? '0 : win + 1'b1;
`endif
            tag1_v <= any;
            tag1   <= oh;
            if (tag1_v) begin
                rdata    <= rom_q;
                rvalid_q <= tag1;
            end else begin
                rvalid_q <= '0;
            end
        end
    end

    // A return landing in a reset cycle belongs to a flushed read, so hide it.
    assign rvalid = Reset ? '0 : rvalid_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter with a behavioural ROM (ROM[k] = k ^ 8'h5A).
module tb_rom_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 8;

    logic            vga_clk = 1'b0;
    logic            Reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_address;
    logic [DW-1:0]   rom_q;
    logic [DW-1:0]   rdata;
    logic [N-1:0]    rvalid;

    always #5 vga_clk = ~vga_clk;

    always_ff @(posedge vga_clk) rom_q <= rom_address[7:0] ^ 8'h5A;

    rom_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .vga_clk(vga_clk), .Reset(Reset), .req(req), .addr(addr), .gnt(gnt),
        .rom_address(rom_address), .rom_q(rom_q), .rdata(rdata), .rvalid(rvalid)
    );

    typedef struct {
        int            due;
        logic [N-1:0]  id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            mptr = 0;
    logic [DW-1:0] last_rdata = '0;
    logic [N-1:0]  last_eg = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs at the falling edge against the model, then advance.
    task automatic step();
        int            w;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        exp_t          e;
        @(negedge vga_clk);
        w = -1;
        for (int j = 0; j < N; j++) begin
            int k;
            k = (mptr + j) % N;
            if (w < 0 && req[k]) w = k;
        end
        eg = '0;
        ea = '0;
        if (!Reset && w >= 0) begin
            eg[w] = 1'b1;
            ea    = addr[w*AW +: AW];
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rom_address", 32'(rom_address), 32'(ea));
        if (Reset) begin
            chk("rvalid_in_reset", 32'(rvalid), 32'd0);
            sbq.delete();
        end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rvalid", 32'(rvalid), 32'(e.id));
            chk("rdata", 32'(rdata), 32'(e.data));
            last_rdata = e.data;
        end else begin
            chk("rvalid_idle", 32'(rvalid), 32'd0);
            chk("rdata_hold", 32'(rdata), 32'(last_rdata));
        end
        if (Reset) begin
            mptr       = 0;
            last_rdata = '0;
        end else if (w >= 0) begin
            e.due  = cyc + 2;
            e.id   = eg;
            e.data = ea[7:0] ^ 8'h5A;
            sbq.push_back(e);
`ifndef ROM_ARB_FIXED_PRI_EN
            mptr = (w + 1) % N;
`endif
        end
        last_eg = eg;
        cyc++;
        @(posedge vga_clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        req   = '0;
        addr  = '0;
        @(posedge vga_clk);
        #1;
        step();
        Reset = 1'b0;

        // single request, two-cycle latency
        req = 4'b0100;
        addr[2*AW +: AW] = 10'h013;
        #1;
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_addr", 32'(rom_address), 32'h013);
        step();
        req = '0;
        step();
        chk("single_rvalid", 32'(rvalid), 32'h4);
        chk("single_rdata", 32'(rdata), 32'h49);
        repeat (3) step();

        // all four requesting continuously from reset
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(10'h100 + i * 33);
        req = 4'hF;
        repeat (12) step();

        // wrap and skip
        req = 4'b0010;
        #1;
        chk("skip_gnt1", 32'(gnt), 32'h2);
        step();
        req = 4'b1001;
        #1;
`ifdef ROM_ARB_FIXED_PRI_EN
        chk("fixed_gnt0", 32'(gnt), 32'h1);
`else
        chk("wrap_gnt3", 32'(gnt), 32'h8);
`endif
        step();

        // reset mid-flight
        req = 4'b0001;
        step();
        req = 4'b0100;
        step();
        Reset = 1'b1;
        req   = 4'hF;
        step();
        Reset = 1'b0;
        #1;
        chk("post_reset_gnt0", 32'(gnt), 32'h1);
        chk("post_reset_rvalid", 32'(rvalid), 32'h0);
        step();
        req = '0;

        // idle
        repeat (10) step();

        // random traffic obeying the hold-until-granted rule
        repeat (80) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || last_eg[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    addr[i*AW +: AW] = AW'($urandom);
                end
            end
            step();
        end
        req = '0;
        repeat (3) step();

        // two contending requesters held
        req = 4'b1010;
        repeat (8) begin
            #1;
`ifdef ROM_ARB_FIXED_PRI_EN
            chk("fixed_pri_gnt", 32'(gnt), 32'h2);
`endif
            step();
        end
        req = '0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Round-robin arbiter that shares one synchronous, single-port sprite/palette-index ROM (address in, registered `q` out one cycle later) among up to N pixel-fetch requesters in the VGA render path, such as the background tile renderer and the tank and bullet sprite renderers. It grants at most one requester per `vga_clk` cycle and drives the ROM address. It tracks each in-flight read and returns the ROM data to the owning requester with a one-hot valid strobe. It sits between the renderers and the ROM instance, so adding a sprite layer no longer needs a duplicated ROM.

## Interface
- `N_REQ`, 4: number of requesters, 2–8.
- `ADDR_W`, 10: ROM address width.
- `DATA_W`, 8: ROM word width (palette index).
- `vga_clk` in 1: the single clock; all state on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `req` in N_REQ: per-requester read request (level).
- `addr` in N_REQ*ADDR_W: packed request addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `gnt` out N_REQ: one-hot grant, combinational in the request cycle.
- `rom_address` out ADDR_W: to the ROM `address` port.
- `rom_q` in DATA_W: from the ROM `q` port.
- `rdata` out DATA_W: registered return data, shared by all requesters.
- `rvalid` out N_REQ: registered one-hot; bit i qualifies `rdata` for requester i.

## Operation
- Handshake rules:
  - A requester asserts `req[i]` with a stable `addr[i]` and holds both until it sees `gnt[i]` high in the same cycle.
  - A grant is a completed transfer.
  - The requester may deassert `req` or present a new address on the next cycle.
- Arbitration (round-robin):
  - State is pointer `ptr` (log2 N_REQ bits, reset 0).
  - The winner is the first asserted `req` scanning `ptr`, `ptr+1`, … with wrap mod N_REQ.
  - After a grant to index w, `ptr` becomes (w+1) mod N_REQ.
  - With no request, `ptr` holds.
- `rom_address` equals `addr[winner]` when any request is present, otherwise 0. It is combinational from `req`/`addr`/`ptr`.
- Pipeline tags:
  - Stage 1 registers `tag1_v` and the one-hot `tag1`, meaning "`rom_q` next cycle belongs to requester w".
  - Stage 2 registers `rdata <= rom_q` and `rvalid <= tag1` when `tag1_v`.
  - Otherwise `rvalid <= 0` and `rdata` holds.
- Throughput: one grant per cycle sustained. Back-to-back grants to different requesters return in grant order.
- A single requester holding `req` continuously is granted every cycle only while it is the sole requester. With k active requesters, each is granted at least once every k cycles.

## Timing
- Latency:
  - Cycle T: `gnt[i]` high.
  - Cycle T+1: ROM drives `rom_q`.
  - Cycle T+2: `rvalid[i]` = 1 and `rdata` = ROM[addr].
  - Fixed 2 cycles, no stalls.
- Reset values: `ptr`=0, `tag1_v`=0, `tag1`=0, `rvalid`=0, `rdata`=0.
- While `Reset` is high:
  - `gnt`=0 and `rom_address`=0.
  - Grants issued in the cycle Reset asserts are discarded, with no `rvalid`.
- Reset mid-operation: reads in flight in stages 1–2 are dropped. The first `rvalid` after release comes 2 cycles after the first post-reset grant.
- Simultaneous events:
  - A grant and a return for the same requester in one cycle are legal; `gnt[i]` and `rvalid[i]` may both be high.
  - All N requests in one cycle: exactly one `gnt` bit.
- Wrap-around: when `ptr`=N_REQ-1 and a grant goes to N_REQ-1, `ptr` becomes 0.

## Configuration
- `ROM_ARB_FIXED_PRI_EN`:
  - Defined: fixed priority, lowest index wins. `ptr` is removed, tied to 0 and never updated, and starvation of high indices is permitted. Intended for a renderer that must never miss its pixel deadline (index 0).
  - Undefined (default): round-robin as above.
  - Latency and handshake are identical in both modes.

## Test plan
- Single request, latency:
  - Stimulus: N_REQ=4, ROM[k]=k^8'h5A; `req[2]`=1, `addr[2]`=10'h013 for one cycle.
  - Required: `gnt`=4'b0100 that cycle and `rom_address`=10'h013; two cycles later `rvalid`=4'b0100, `rdata`=8'h49, then `rvalid`=0.
- All four requesting continuously from reset:
  - Required: grant order 0,1,2,3,0,1…
  - Required: `rvalid` sequence is the same order delayed 2 cycles, each with the correct data.
- Wrap and skip:
  - Stimulus: after a grant to 3, only `req[1]` asserted.
  - Required: grant to 1, then `ptr`=2; next cycle `req[0]` and `req[3]` both asserted, so 3 is granted.
- Reset mid-flight:
  - Stimulus: grants issued at T and T+1; `Reset` high at T+2 for one cycle.
  - Required: no `rvalid` at T+2 or T+3, and post-reset arbitration starts at index 0.
- Idle:
  - Stimulus: no requests for 10 cycles.
  - Required: `gnt`=0, `rom_address`=0, `rvalid`=0, `rdata` holds its last value.
- With `ROM_ARB_FIXED_PRI_EN`:
  - Stimulus: `req`=4'b1010 held.
  - Required: `gnt`=4'b0010 every cycle and requester 3 is never granted.
